// File: rtl/vc_input_unit.sv
// Router input unit: one FWFT FIFO and IDLE/WAITING/ACTIVE FSM per virtual channel,
// XY route computation on header flits and round-robin selection toward the output stage.
module vc_input_unit #(
  parameter int NUM_VC      = 2,
  parameter int VC_DEPTH_W  = 2,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int COL_CORD    = 1,
  parameter int ROW_CORD    = 1,
  parameter int COL_ADDR_W  = 2,
  parameter int ROW_ADDR_W  = 2,
  parameter int HEADER_ID   = 0,
  parameter int TAIL_ID     = 3,
  localparam int FLIT_W     = FLIT_DATA_W + FLIT_ID_W,
  localparam int VC_ID_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int OUT_M      = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FLIT_W-1:0]  data_i,
  input  logic [VC_ID_W-1:0] vc_id_i,
  input  logic               wr_en_i,
  output logic [NUM_VC-1:0]  credit_o,
  output logic               overflow_o,
  output logic               err_o,
  output logic [OUT_M-1:0]   oc_req_o,
  output logic [VC_ID_W-1:0] oc_vc_o,
  input  logic               oc_granted_i,
  output logic [FLIT_W-1:0]  oc_data_o,
  output logic               oc_data_vld_o,
  input  logic               oc_rdy_i
);

  localparam int DEPTH = 1 << VC_DEPTH_W;
  localparam logic [VC_DEPTH_W:0]   FULL_CNT = (VC_DEPTH_W + 1)'(DEPTH);
  localparam logic [FLIT_ID_W-1:0]  HDR_TYPE = FLIT_ID_W'(HEADER_ID);
  localparam logic [FLIT_ID_W-1:0]  TAIL_TYPE = FLIT_ID_W'(TAIL_ID);
  localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
  localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);

  typedef enum logic [1:0] {IDLE, WAITING, ACTIVE} vc_state_t;

  logic [FLIT_W-1:0]     mem      [NUM_VC][DEPTH];
  logic [VC_DEPTH_W-1:0] rd_ptr   [NUM_VC];
  logic [VC_DEPTH_W-1:0] wr_ptr   [NUM_VC];
  logic [VC_DEPTH_W:0]   fill     [NUM_VC];
  vc_state_t             state    [NUM_VC];
  logic [OUT_M-1:0]      route    [NUM_VC];
  logic [FLIT_W-1:0]     head     [NUM_VC];
  logic [OUT_M-1:0]      head_route [NUM_VC];
  logic [VC_ID_W-1:0]    rr;
  logic                  overflow_q;

  logic [NUM_VC-1:0] empty, full, is_header, is_tail, eligible, discard, deq, wr_hit, accept;
  logic [VC_ID_W-1:0] sel;
  logic               sel_found, grant_fire, data_vld, xfer;

  // Bit order of the request vector: LOCAL, EAST, WEST, NORTH, SOUTH.
  function automatic logic [OUT_M-1:0] calc_route(input logic [FLIT_W-1:0] f);
    logic [COL_ADDR_W-1:0] col;
    logic [ROW_ADDR_W-1:0] row;
    col = f[ROW_ADDR_W +: COL_ADDR_W];
    row = f[ROW_ADDR_W-1:0];
    if (col > MY_COL)      return 5'b00010;
    else if (col < MY_COL) return 5'b00100;
    else if (row > MY_ROW) return 5'b10000;
    else if (row < MY_ROW) return 5'b01000;
    else                   return 5'b00001;
  endfunction

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      head[v]       = mem[v][rd_ptr[v]];
      head_route[v] = calc_route(head[v]);
      empty[v]      = (fill[v] == '0);
      full[v]       = (fill[v] == FULL_CNT);
      is_header[v]  = (head[v][FLIT_W-1 -: FLIT_ID_W] == HDR_TYPE);
      is_tail[v]    = (head[v][FLIT_W-1 -: FLIT_ID_W] == TAIL_TYPE);
      eligible[v]   = (state[v] == WAITING) || ((state[v] == ACTIVE) && !empty[v]);
      discard[v]    = (state[v] == IDLE) && !empty[v] && !is_header[v];
      wr_hit[v]     = wr_en_i && (vc_id_i == VC_ID_W'(v));
    end
  end

  always_comb begin
    int unsigned idx;
    logic [VC_ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      idx = 32'(rr) + i;
      if (idx >= 32'(NUM_VC)) idx = idx - 32'(NUM_VC);
      cand = VC_ID_W'(idx);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  assign grant_fire = sel_found && (state[sel] == WAITING) && oc_granted_i;
  assign data_vld   = sel_found && (state[sel] == ACTIVE) && !empty[sel];
  assign xfer       = data_vld && oc_rdy_i;

  // A full FIFO still accepts a write when the same VC dequeues in that cycle.
  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      deq[v]    = discard[v] || (xfer && (sel == VC_ID_W'(v)));
      accept[v] = wr_hit[v] && (!full[v] || deq[v]);
    end
  end

  assign credit_o      = deq;
  assign err_o         = |discard;
  assign overflow_o    = overflow_q;
  assign oc_vc_o       = sel;
  assign oc_req_o      = (sel_found && (state[sel] == WAITING)) ? route[sel] : '0;
  assign oc_data_vld_o = data_vld;
  assign oc_data_o     = data_vld ? head[sel] : '0;

  always_ff @(posedge clk_i) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (accept[v]) mem[v][wr_ptr[v]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr         <= '0;
      overflow_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        state[v]  <= IDLE;
        route[v]  <= '0;
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        fill[v]   <= '0;
      end
    end else begin
      overflow_q <= |(wr_hit & ~accept);
      if (grant_fire || xfer)
        rr <= (32'(sel) + 32'd1 >= 32'(NUM_VC)) ? '0 : sel + 1'b1;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (accept[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (deq[v])    rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (accept[v] && !deq[v])      fill[v] <= fill[v] + 1'b1;
        else if (!accept[v] && deq[v]) fill[v] <= fill[v] - 1'b1;
        unique case (state[v])
          IDLE: begin
            if (!empty[v] && is_header[v]) begin
              state[v] <= WAITING;
              route[v] <= head_route[v];
            end
          end
          WAITING: begin
            if (grant_fire && (sel == VC_ID_W'(v))) state[v] <= ACTIVE;
          end
          ACTIVE: begin
            if (xfer && (sel == VC_ID_W'(v)) && is_tail[v]) state[v] <= IDLE;
          end
          default: state[v] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit with default parameters (2 VCs, depth 4, router at column 1 / row 1).
module tb_vc_input_unit;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [9:0] data_i = '0;
  logic       vc_id_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic       oc_granted_i = 1'b0;
  logic       oc_rdy_i = 1'b0;
  logic [1:0] credit_o;
  logic       overflow_o, err_o, oc_vc_o, oc_data_vld_o;
  logic [4:0] oc_req_o;
  logic [9:0] oc_data_o;

  int vectors = 0;
  int miscompares = 0;

  vc_input_unit #(.NUM_VC(2), .VC_DEPTH_W(2), .FLIT_DATA_W(8), .FLIT_ID_W(2),
                  .COL_CORD(1), .ROW_CORD(1), .COL_ADDR_W(2), .ROW_ADDR_W(2),
                  .HEADER_ID(0), .TAIL_ID(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .vc_id_i(vc_id_i), .wr_en_i(wr_en_i),
    .credit_o(credit_o), .overflow_o(overflow_o), .err_o(err_o),
    .oc_req_o(oc_req_o), .oc_vc_o(oc_vc_o), .oc_granted_i(oc_granted_i),
    .oc_data_o(oc_data_o), .oc_data_vld_o(oc_data_vld_o), .oc_rdy_i(oc_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  wire [20:0] obs = {oc_req_o, oc_vc_o, oc_data_vld_o, oc_data_o, credit_o, err_o, overflow_o};

  function automatic logic [20:0] ev(logic [4:0] req, logic vc, logic vld, logic [9:0] d,
                                     logic [1:0] cr, logic er, logic ov);
    return {req, vc, vld, d, cr, er, ov};
  endfunction

  function automatic logic [9:0] hdr(logic [3:0] tag, logic [1:0] col, logic [1:0] row);
    return {2'b00, tag, col, row};
  endfunction
  function automatic logic [9:0] body(logic [7:0] p); return {2'b01, p}; endfunction
  function automatic logic [9:0] tail(logic [7:0] p); return {2'b11, p}; endfunction

  task automatic cyc(); @(posedge clk_i); #1; endtask

  task automatic drive(input logic en, input logic vc, input logic [9:0] d);
    wr_en_i = en; vc_id_i = vc; data_i = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; drive(1'b0, 1'b0, '0); oc_granted_i = 1'b0; oc_rdy_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    #1 rst_i = 1'b1;
    oc_granted_i = 1'b1; oc_rdy_i = 1'b1; drive(1'b1, 1'b0, hdr(4'h1, 2'd1, 2'd1));
    repeat (2) @(posedge clk_i);
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rst_hold: got %h required %h", obs, e); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [20:0] e;
    logic [9:0] h, b, t;
    h = hdr(4'hA, 2'd3, 2'd1); b = body(8'h5B); t = tail(8'hC7);
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b1;
    drive(1'b1, 1'b0, h);
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_empty: got %h required %h", obs, e); end
    cyc(); drive(1'b1, 1'b0, b);
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_idle_hdr: got %h required %h", obs, e); end
    cyc(); drive(1'b1, 1'b0, t);
    #1 e = ev(5'b00010, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_east_req: got %h required %h", obs, e); end
    cyc(); drive(1'b0, 1'b0, '0);
    #1 e = ev(5'b0, 1'b0, 1'b1, h, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_xfer_h: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b1, b, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_xfer_b: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b1, t, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_xfer_t: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_drained: got %h required %h", obs, e); end
    oc_granted_i = 1'b0; drive(1'b1, 1'b0, hdr(4'h1, 2'd1, 2'd1));
    cyc(); drive(1'b0, 1'b0, '0);
    cyc();
    e = ev(5'b00001, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL sp_back_idle: got %h required %h", obs, e); end
  endtask

  task automatic test_interleave();
    logic [20:0] e;
    logic [9:0] h0, b0, t0, h1, b1, t1;
    logic [9:0] exp_d [6];
    logic       exp_vc [6];
    int n, c0, c1;
    h0 = hdr(4'h2, 2'd1, 2'd0); b0 = body(8'h21); t0 = tail(8'h22);
    h1 = hdr(4'h3, 2'd1, 2'd1); b1 = body(8'h31); t1 = tail(8'h32);
    exp_d = '{h0, h1, b0, b1, t0, t1};
    exp_vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b0;
    drive(1'b1, 1'b0, h0); cyc();
    drive(1'b1, 1'b0, b0); cyc();
    drive(1'b1, 1'b0, t0);
    #1 e = ev(5'b01000, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL il_north_req: got %h required %h", obs, e); end
    cyc(); drive(1'b1, 1'b1, h1); cyc();
    drive(1'b1, 1'b1, b1);
    #1 e = ev(5'b0, 1'b0, 1'b1, h0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL il_stall: got %h required %h", obs, e); end
    cyc(); drive(1'b1, 1'b1, t1);
    #1 e = ev(5'b00001, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL il_local_req: got %h required %h", obs, e); end
    cyc(); drive(1'b0, 1'b0, '0); oc_rdy_i = 1'b1;
    n = 0; c0 = 0; c1 = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      c0 += int'(credit_o[0]); c1 += int'(credit_o[1]);
      if (oc_data_vld_o) begin
        if (n < 6) begin
          vectors++;
          if ({oc_vc_o, oc_data_o, credit_o} !== {exp_vc[n], exp_d[n], exp_vc[n] ? 2'b10 : 2'b01}) begin
            miscompares++;
            $display("FAIL il_xfer%0d: got vc=%0d data=%h credit=%b required vc=%0d data=%h",
                     n, oc_vc_o, oc_data_o, credit_o, exp_vc[n], exp_d[n]);
          end
        end
        n++;
      end
      cyc();
    end
    vectors++;
    if (n != 6 || c0 != 3 || c1 != 3) begin
      miscompares++;
      $display("FAIL il_counts: got xfers=%0d credit0=%0d credit1=%0d required 6/3/3", n, c0, c1);
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] e;
    logic [9:0] h, b, t;
    h = hdr(4'h4, 2'd2, 2'd1); b = body(8'h41); t = tail(8'h42);
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b0;
    drive(1'b1, 1'b0, h); cyc();
    drive(1'b1, 1'b0, b); cyc();
    drive(1'b1, 1'b0, t); cyc();
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      #1 e = ev(5'b0, 1'b0, 1'b1, h, 2'b00, 1'b0, 1'b0); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL bp_hold%0d: got %h required %h", k, obs, e); end
      cyc();
    end
    oc_rdy_i = 1'b1;
    #1 e = ev(5'b0, 1'b0, 1'b1, h, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bp_release: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b1, b, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bp_next: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b1, t, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bp_tail: got %h required %h", obs, e); end
  endtask

  task automatic test_overflow();
    logic [20:0] e;
    logic [9:0] exp_d [4];
    int n;
    exp_d = '{hdr(4'h5, 2'd1, 2'd1), body(8'h51), body(8'h52), tail(8'h53)};
    do_reset(); oc_granted_i = 1'b0; oc_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, exp_d[k]); cyc();
    end
    drive(1'b1, 1'b1, body(8'h54));
    #1 e = ev(5'b00001, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL ov_before: got %h required %h", obs, e); end
    cyc(); drive(1'b0, 1'b0, '0);
    #1 e = ev(5'b00001, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b1); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL ov_pulse: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b00001, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL ov_once: got %h required %h", obs, e); end
    oc_granted_i = 1'b1; oc_rdy_i = 1'b1;
    cyc();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (oc_data_vld_o) begin
        if (n < 4) begin
          vectors++;
          if ({oc_vc_o, oc_data_o, credit_o} !== {1'b1, exp_d[n], 2'b10}) begin
            miscompares++;
            $display("FAIL ov_xfer%0d: got vc=%0d data=%h credit=%b required vc=1 data=%h credit=10",
                     n, oc_vc_o, oc_data_o, credit_o, exp_d[n]);
          end
        end
        n++;
      end
      cyc();
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL ov_count: got %0d transfers required 4", n); end
  endtask

  task automatic test_full_write_dequeue();
    logic [20:0] e;
    logic [9:0] h;
    logic [9:0] exp_d [4];
    int n;
    h = hdr(4'h6, 2'd1, 2'd3);
    exp_d = '{body(8'h61), body(8'h62), body(8'h63), tail(8'h64)};
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b0;
    drive(1'b1, 1'b0, h); cyc();
    drive(1'b1, 1'b0, exp_d[0]); cyc();
    drive(1'b1, 1'b0, exp_d[1]);
    #1 e = ev(5'b10000, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL fw_south_req: got %h required %h", obs, e); end
    cyc(); drive(1'b1, 1'b0, exp_d[2]); cyc();
    oc_rdy_i = 1'b1; drive(1'b1, 1'b0, exp_d[3]);
    #1 e = ev(5'b0, 1'b0, 1'b1, h, 2'b01, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL fw_full_xfer: got %h required %h", obs, e); end
    cyc(); drive(1'b0, 1'b0, '0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 0) begin
        vectors++;
        if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL fw_no_overflow: got %b required 0", overflow_o); end
      end
      if (oc_data_vld_o) begin
        if (n < 4) begin
          vectors++;
          if ({oc_data_o, credit_o} !== {exp_d[n], 2'b01}) begin
            miscompares++;
            $display("FAIL fw_xfer%0d: got data=%h credit=%b required data=%h credit=01",
                     n, oc_data_o, credit_o, exp_d[n]);
          end
        end
        n++;
      end
      cyc();
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL fw_count: got %0d transfers required 4", n); end
  endtask

  task automatic test_err();
    logic [20:0] e;
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b1;
    drive(1'b1, 1'b0, body(8'h77)); cyc();
    drive(1'b0, 1'b0, '0);
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b01, 1'b1, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL er_vc0_pulse: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL er_vc0_once: got %h required %h", obs, e); end
    drive(1'b1, 1'b1, tail(8'h78)); cyc();
    drive(1'b0, 1'b0, '0);
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b10, 1'b1, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL er_vc1_pulse: got %h required %h", obs, e); end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e;
    logic [9:0] h;
    h = hdr(4'h8, 2'd0, 2'd1);
    do_reset(); oc_granted_i = 1'b1; oc_rdy_i = 1'b0;
    drive(1'b1, 1'b0, h); cyc();
    drive(1'b1, 1'b0, body(8'h81)); cyc();
    drive(1'b0, 1'b0, '0);
    #1 e = ev(5'b00100, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_west_req: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b0, 1'b0, 1'b1, h, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_active: got %h required %h", obs, e); end
    oc_rdy_i = 1'b1;
    #1 rst_i = 1'b1;
    #1 e = ev(5'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_async: got %h required %h", obs, e); end
    @(posedge clk_i);
    #1 vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_held: got %h required %h", obs, e); end
    #2 rst_i = 1'b0;
    drive(1'b1, 1'b1, hdr(4'h9, 2'd1, 2'd3));
    cyc(); drive(1'b0, 1'b0, '0);
    #1 vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_after: got %h required %h", obs, e); end
    cyc();
    e = ev(5'b10000, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rm_first_write: got %h required %h", obs, e); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied so far", vectors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_interleave();
    test_backpressure();
    test_overflow();
    test_full_write_dequeue();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
